ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the EX stage of the forwarding pipelined CPU. It consumes the post-forwarding RS/RT operands and the M-extension op selected in EX. It computes the 32-bit result over a fixed number of cycles and holds `busy_o` high so the hazard unit freezes PC, IF/ID and ID/EX until the result is available. On the cycle `done_o` is high, EX forwards `result_o` into EX/MEM in place of the ALU result.

---
 rtl/ex_muldiv_pkg.sv | 44 ++++
 rtl/ex_muldiv_if.sv | 25 ++
 rtl/ex_muldiv.sv | 141 ++++++++++++++
 tb/tb_ex_muldiv.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes,
// FSM states, default width and op-decoding helpers.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL   = 3'b000,
    OP_MULH  = 3'b001,
    OP_MULHU = 3'b010,
    OP_MULR  = 3'b011,  // reserved encoding, behaves as MUL
    OP_DIV   = 3'b100,
    OP_DIVU  = 3'b101,
    OP_REM   = 3'b110,
    OP_REMU  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Divide family is the upper half of the encoding.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Remainder ops within the divide family.
  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // MUL is sign-agnostic for its low word, so only these three need magnitudes.
  function automatic logic is_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic want_high(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Handshake bundle between the EX stage and the multiply/divide unit.
//   start_i/op_i/rs_i/rt_i/flush_i : request side, driven by EX
//   busy_o/done_o/result_o         : response side, driven by the unit
interface ex_muldiv_if #(
  parameter int unsigned XLEN = muldiv_pkg::XLEN
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs_i;
  logic [XLEN-1:0] rt_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, rs_i, rt_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, rs_i, rt_i, flush_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   bus     : slave side of ex_muldiv_if (start/op/operands/flush in,
//             busy/done/result out)
// Multiply is shift-add into a 64-bit accumulator; divide is restoring with a
// 33-bit partial remainder. Both run on operand magnitudes and share the
// accumulator; signs are reapplied in FIX.
module ex_muldiv #(
  parameter int unsigned XLEN = muldiv_pkg::XLEN,
  parameter int unsigned ITER = XLEN
) (
  input  logic        clk_i,
  input  logic        rst_i,
  ex_muldiv_if.slave  bus
);
  import muldiv_pkg::*;

  localparam int unsigned CW = $clog2(ITER);
  localparam int unsigned W2 = 2 * XLEN;

  state_e          state, state_nx;
  logic [CW-1:0]   count;
  logic [2:0]      op_q;
  logic            sa_q, sb_q;
  logic [XLEN-1:0] m_q;       // multiplicand (mul) or divisor (div) magnitude
  logic [W2-1:0]   acc;
  logic [XLEN-1:0] result_q;

  // Acceptance-cycle decode
  logic            accept_ok, sgn, a_neg, b_neg, div_zero, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    accept_ok = ((state == S_IDLE) || (state == S_DONE)) && bus.start_i && !bus.flush_i;
    sgn       = is_signed(bus.op_i);
    a_neg     = sgn & bus.rs_i[XLEN-1];
    b_neg     = sgn & bus.rt_i[XLEN-1];
    // Two's-complement negation of 0x80000000 yields 0x80000000, which is
    // the correct unsigned magnitude.
    a_mag     = a_neg ? XLEN'(-bus.rs_i) : bus.rs_i;
    b_mag     = b_neg ? XLEN'(-bus.rt_i) : bus.rt_i;
    div_zero  = is_div(bus.op_i) && (bus.rt_i == '0);
    ovf       = sgn && is_div(bus.op_i)
                && (bus.rs_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rt_i == '1);
    special   = div_zero || ovf;
    if (div_zero)
      special_res = is_rem(bus.op_i) ? bus.rs_i : '1;
    else
      special_res = is_rem(bus.op_i) ? '0 : bus.rs_i;
  end

  // One iteration step of each algorithm
  logic [XLEN:0]   msum, rem_sh, diff;
  logic [XLEN-1:0] rem_nx;
  logic            qbit;
  logic [W2-1:0]   mul_nx, div_nx;

  always_comb begin
    msum   = {1'b0, acc[W2-1:XLEN]} + (acc[0] ? {1'b0, m_q} : '0);
    mul_nx = {msum, acc[XLEN-1:1]};
    rem_sh = {acc[W2-1:XLEN], acc[XLEN-1]};
    diff   = rem_sh - {1'b0, m_q};
    qbit   = ~diff[XLEN];
    rem_nx = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    div_nx = {rem_nx, acc[XLEN-2:0], qbit};
  end

  // Sign correction
  logic [W2-1:0]   prod;
  logic [XLEN-1:0] mul_res, quo, rmd, fix_res;

  always_comb begin
    prod    = (sa_q ^ sb_q) ? W2'(-acc) : acc;
    mul_res = want_high(op_q) ? prod[W2-1:XLEN] : prod[XLEN-1:0];
    quo     = (sa_q ^ sb_q) ? XLEN'(-acc[XLEN-1:0]) : acc[XLEN-1:0];
    rmd     = sa_q ? XLEN'(-acc[W2-1:XLEN]) : acc[W2-1:XLEN];
    if (is_div(op_q))
      fix_res = is_rem(op_q) ? rmd : quo;
    else
      fix_res = mul_res;
  end

  // Next-state logic; flush wins over start
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept_ok) state_nx = special ? S_DONE : S_CALC;
      S_CALC: begin
        if (bus.flush_i)                      state_nx = S_IDLE;
        else if (count == CW'(ITER - 1))      state_nx = S_FIX;
      end
      S_FIX:  state_nx = bus.flush_i ? S_IDLE : S_DONE;
      S_DONE: begin
        if (accept_ok) state_nx = special ? S_DONE : S_CALC;
        else           state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Operand latch, iteration and result register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      m_q      <= '0;
      acc      <= '0;
      result_q <= '0;
    end else if (accept_ok) begin
      op_q  <= bus.op_i;
      sa_q  <= a_neg;
      sb_q  <= b_neg;
      count <= '0;
      if (special) begin
        result_q <= special_res;
      end else begin
        acc <= is_div(bus.op_i) ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
        m_q <= is_div(bus.op_i) ? b_mag : a_mag;
      end
    end else if (state == S_CALC) begin
      acc   <= is_div(op_q) ? div_nx : mul_nx;
      count <= count + CW'(1);
    end else if ((state == S_FIX) && !bus.flush_i) begin
      result_q <= fix_res;
    end
  end

  assign bus.busy_o   = ((state == S_IDLE) && bus.start_i && !special)
                        || (state == S_CALC) || (state == S_FIX);
  assign bus.done_o   = (state == S_DONE);
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expected result and done
// cycle; a negedge monitor pops and compares on every done pulse.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  ex_muldiv_if bus ();

  ex_muldiv #(.XLEN(32), .ITER(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.done_o) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result %h at cycle %0d, want no done", bus.result_o, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", bus.result_o, mon_e.res);
        check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic push_exp(input logic [31:0] res, input int at);
    exp_t e;
    e.res = res;
    e.cyc = at;
    sb_q.push_back(e);
  endtask

  // Issue one op, scramble inputs after acceptance, count busy cycles to done
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] want, input bit special);
    int nb;
    bit seen;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.rs_i    = a;
    bus.rt_i    = b;
    push_exp(want, cyc + (special ? 1 : 34));
    #1 check({name, "_busy_c0"}, 32'(bus.busy_o), 32'(!special));
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.op_i    = ~op;
    bus.rs_i    = ~a;
    bus.rt_i    = b ^ 32'h5a5a_a5a5;
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
      else if (bus.busy_o) nb++;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done, want done", name);
    end
    check({name, "_busy_cycles"}, 32'(nb), special ? 32'd0 : 32'd33);
  endtask

  initial begin
    int c0;
    bit seen;
    bus.start_i = 1'b0;
    bus.op_i    = '0;
    bus.rs_i    = '0;
    bus.rt_i    = '0;
    bus.flush_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_result", bus.result_o, 32'h0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy_o), 32'd0);

    run_op("mul_7_m3",  OP_MUL,   32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op("mulhu_ff",  OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("mulh_ff",   OP_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    run_op("mul_ff",    OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("mulh_min",  OP_MULH,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op("div_m7_2",  OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0);
    run_op("rem_m7_2",  OP_REM,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0);
    run_op("divu_m7_2", OP_DIVU,  32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 1'b0);
    run_op("remu_m7_2", OP_REMU,  32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 1'b0);
    run_op("divu_z",    OP_DIVU,  32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1);
    run_op("rem_z",     OP_REM,   32'd5,        32'd0,        32'h0000_0005, 1'b1);
    run_op("div_z",     OP_DIV,   32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1);
    run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("rem_ovf",   OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    run_op("mul_resv",  OP_MULR,  32'd6,        32'd7,        32'd42,        1'b0);

    // Flush in cycle 10 of a DIV: no done, result retained
    @(negedge clk);
    c0 = cyc;
    bus.start_i = 1'b1;
    bus.op_i    = OP_DIV;
    bus.rs_i    = 32'd100;
    bus.rt_i    = 32'd7;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    do @(negedge clk); while (cyc < c0 + 10);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(bus.busy_o), 32'd0);
    check("flush_done", 32'(bus.done_o), 32'd0);
    check("flush_result", bus.result_o, 32'd42);
    repeat (40) @(negedge clk);
    check("flush_result_late", bus.result_o, 32'd42);

    // Back-to-back: second op accepted in the first op's done cycle
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = OP_MUL;
    bus.rs_i    = 32'd3;
    bus.rt_i    = 32'd5;
    push_exp(32'd15, cyc + 34);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL b2b_timeout: got no done, want done");
    end
    bus.start_i = 1'b1;
    bus.op_i    = OP_MUL;
    bus.rs_i    = 32'h1234;
    bus.rt_i    = 32'h10;
    push_exp(32'h0001_2340, cyc + 34);
    #1 check("b2b_busy_in_done", 32'(bus.busy_o), 32'd0);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    @(negedge clk);
    check("b2b_done_once", 32'(bus.done_o), 32'd0);
    check("b2b_busy_calc", 32'(bus.busy_o), 32'd1);
    check("b2b_result_held", bus.result_o, 32'd15);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL b2b2_timeout: got no done, want done");
    end

    // Reset mid-CALC: outputs return to reset values immediately
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = OP_MUL;
    bus.rs_i    = 32'd9;
    bus.rt_i    = 32'd9;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_result", bus.result_o, 32'h0);
    check("rst_mid_done", 32'(bus.done_o), 32'd0);
    check("rst_mid_busy", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_mid_quiet", bus.result_o, 32'h0);

    run_op("mulhu_post", OP_MULHU, 32'h8000_0000, 32'd4, 32'h0000_0002, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
